// File: rtl/block_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to include the even-parity bit in every frame.
module block_tx #(
    parameter int REFERENCE_CLOCK = 50000000,
    parameter int BAUD            = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] DATA_TX,
    input  logic       TX_Send,
    output logic       TX_Port,
    output logic       TX_Busy,
    output logic       TX_Done
);

    localparam int DIV = REFERENCE_CLOCK / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          port_n, busy_n, done_n;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    assign bit_end = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            TX_Port <= 1'b1;
            TX_Busy <= 1'b0;
            TX_Done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift   <= shift_n;
            TX_Port <= port_n;
            TX_Busy <= busy_n;
            TX_Done <= done_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    // The line value for the next bit is chosen on the edge that ends the current one,
    // so the registered TX_Port switches exactly on bit boundaries.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        port_n  = TX_Port;
        busy_n  = TX_Busy;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                port_n = 1'b1;
                if (TX_Send) begin
                    shift_n = DATA_TX;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^DATA_TX;
`endif
                    state_n = START;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    port_n  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    idx_n   = '0;
                    port_n  = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        port_n  = par;
`else
                        state_n = STOP;
                        port_n  = 1'b1;
`endif
                    end else begin
                        idx_n  = idx + 3'd1;
                        port_n = shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    port_n  = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    port_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                port_n  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_block_tx.sv
// Testbench for block_tx: per-clock comparison of the line, busy and done against a
// frame-timeline model, plus directed frame, busy-protection, back-to-back and reset cases.
module tb_block_tx;

    localparam int DIV = 8;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (10 + P) * DIV;

    logic       clk;
    logic       reset;
    logic [7:0] DATA_TX;
    logic       TX_Send;
    logic       TX_Port;
    logic       TX_Busy;
    logic       TX_Done;

    int num_compared;
    int num_mismatched;
    int done_pulses;
    int busy_cycles;

    // Model: a frame is a list of line bits indexed by (clocks since acceptance) / DIV.
    logic        m_busy;
    logic        m_done;
    int          m_t;
    logic [10:0] m_frame;

    block_tx #(
        .REFERENCE_CLOCK(8),
        .BAUD           (1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .DATA_TX(DATA_TX),
        .TX_Send(TX_Send),
        .TX_Port(TX_Port),
        .TX_Busy(TX_Busy),
        .TX_Done(TX_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] build_frame(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[1 + k] = b[k];
        if (P == 1) f[9] = ^b;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_compared++;
        if (got !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_t    = 0;
    endtask

    // One clock: the model sees the inputs the DUT saw at the edge, then all outputs are compared.
    task automatic step();
        logic       s;
        logic [7:0] d;
        logic       exp_port;
        s = TX_Send;
        d = DATA_TX;
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (s) begin
                m_busy  = 1'b1;
                m_t     = 0;
                m_frame = build_frame(d);
            end
        end else begin
            m_t++;
            m_done = 1'b0;
            if (m_t == FRAME) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        exp_port = m_busy ? m_frame[m_t / DIV] : 1'b1;
        checkOutput("port", 32'(TX_Port), 32'(exp_port));
        checkOutput("busy", 32'(TX_Busy), 32'(m_busy));
        checkOutput("done", 32'(TX_Done), 32'(m_done));
        if (TX_Done) done_pulses++;
        if (TX_Busy) busy_cycles++;
    endtask

    task automatic applyStimulus(input logic send, input logic [7:0] data, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            TX_Send = send;
            DATA_TX = data;
            step();
        end
    endtask

    task automatic clear_counts();
        done_pulses = 0;
        busy_cycles = 0;
    endtask

    task automatic single_frame(input logic [7:0] b, input string tag);
        clear_counts();
        applyStimulus(1'b1, b, 1);
        applyStimulus(1'b0, 8'h00, FRAME + 4);
        checkOutput({tag, "_busy_len"}, 32'(busy_cycles), 32'(FRAME));
        checkOutput({tag, "_done_cnt"}, 32'(done_pulses), 32'd1);
    endtask

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        clear_counts();
        model_reset();
        m_frame = '1;
        reset   = 1'b0;
        TX_Send = 1'b0;
        DATA_TX = 8'h00;

        applyStimulus(1'b0, 8'h00, 3);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 20);
        checkOutput("idle_done_cnt", 32'(done_pulses), 32'd0);

        single_frame(8'h55, "f55");
        single_frame(8'h07, "f07");

        // Busy protection: a new request and new data mid-frame must be ignored.
        clear_counts();
        applyStimulus(1'b1, 8'h3C, 1);
        applyStimulus(1'b0, 8'h3C, 29);
        applyStimulus(1'b1, 8'hFF, 1);
        applyStimulus(1'b0, 8'hFF, FRAME + 10);
        checkOutput("busyprot_done_cnt", 32'(done_pulses), 32'd1);
        checkOutput("busyprot_busy_len", 32'(busy_cycles), 32'(FRAME));

        // Back-to-back: request held across the end of the first frame.
        clear_counts();
        applyStimulus(1'b1, 8'hA5, FRAME + 2);
        applyStimulus(1'b0, 8'h00, FRAME + 5);
        checkOutput("b2b_done_cnt", 32'(done_pulses), 32'd2);
        checkOutput("b2b_busy_len", 32'(busy_cycles), 32'(2 * FRAME));

        // Reset mid-frame: line returns high at once and the frame is dropped.
        clear_counts();
        applyStimulus(1'b1, 8'h00, 1);
        applyStimulus(1'b0, 8'h00, 34);
        reset = 1'b0;
        #1;
        model_reset();
        checkOutput("rst_port", 32'(TX_Port), 32'd1);
        checkOutput("rst_busy", 32'(TX_Busy), 32'd0);
        checkOutput("rst_done", 32'(TX_Done), 32'd0);
        applyStimulus(1'b0, 8'h00, 3);
        checkOutput("rst_no_done", 32'(done_pulses), 32'd0);
        clear_counts();
        TX_Send = 1'b1;
        reset   = 1'b1;
        applyStimulus(1'b1, 8'h00, 1);
        applyStimulus(1'b0, 8'h00, FRAME + 4);
        checkOutput("rst_fresh_done", 32'(done_pulses), 32'd1);
        checkOutput("rst_fresh_busy", 32'(busy_cycles), 32'(FRAME));

        // Random requests and data churn, including requests while busy.
        for (int i = 0; i < 900; i++) begin
            TX_Send = ($urandom_range(0, 11) == 0);
            DATA_TX = 8'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/block_tx.md
# block_tx

Parity-capable UART transmitter, the transmit-side counterpart to the 16x-oversampling receiver in the UART subsystem. It runs entirely on the system clock and derives the bit period from an internal baud counter, so no external divided clock is needed. It accepts a byte through a level/acknowledge handshake and serialises it LSB-first as start, 8 data bits, an optional even-parity bit, and one stop bit. It reports busy and frame-done status to the controlling logic.

## Interface
- REFERENCE_CLOCK, 50000000: system clock frequency in Hz.
- BAUD, 9600: line bit rate.
- DIV (localparam) = REFERENCE_CLOCK / BAUD, truncating integer division (5208 at defaults); counter width = $clog2(DIV).

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- DATA_TX  input  8  byte to send; sampled only at acceptance.
- TX_Send  input  1  send request, level-sensitive; accepted only in IDLE.
- TX_Port  output  1  serial line, registered; idle high.
- TX_Busy  output  1  high from the acceptance edge until the frame completes.
- TX_Done  output  1  one-clock pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (reset=0, asynchronous): state=IDLE, TX_Port=1, TX_Busy=0, TX_Done=0, baud counter=0, bit index=0, shift register=0.
- IDLE: TX_Port=1. If TX_Send=1 at a clock edge:
  - latch DATA_TX into the shift register;
  - compute parity = XOR of DATA_TX bits (even parity);
  - go to START with TX_Busy=1 and the baud counter cleared.
- START: TX_Port=0 for DIV clocks, then go to DATA with bit index 0.
- DATA: TX_Port = shift[0] for DIV clocks, then shift right.
  - Bit index 0..7; after bit 7, go to PARITY (macro defined) or STOP.
- PARITY: TX_Port = latched parity for DIV clocks, then go to STOP.
- STOP: TX_Port=1 for DIV clocks, then go to IDLE.
  - On that edge: TX_Busy=0 and TX_Done=1 for exactly one clock.
- The baud counter counts 0..DIV-1. A bit ends on the edge where the counter equals DIV-1; the counter wraps to 0 on that edge.
- TX_Send while TX_Busy=1 is ignored, not queued.
- DATA_TX changes after acceptance do not affect the frame in flight.
- TX_Send held high: a new frame is accepted on the first edge in IDLE. This gives exactly one extra idle-high clock between frames.
- Reset mid-frame aborts immediately: TX_Port goes high asynchronously and the partial frame is discarded.

## Timing
- Let E0 be the acceptance edge. TX_Port, TX_Busy and TX_Done are registered and change just after the edge.
- Start bit: E0 to E0+DIV.
- Data bit k: E0+(1+k)·DIV to E0+(2+k)·DIV.
- Parity bit: E0+9·DIV to E0+10·DIV.
- Stop bit: (P+9)·DIV to (P+10)·DIV after E0, where P=1 with parity and 0 without.
- Frame end edge EF = E0 + (10+P)·DIV.
  - At EF: TX_Busy falls and TX_Done rises.
  - At EF+1: TX_Done falls.
  - Earliest next acceptance edge is EF+1.
- Latency from request to start bit: 0 clocks beyond the acceptance edge.

## Configuration
- Macro UART_TX_PARITY_EN.
  - Defined: PARITY state is present; frame is 11 bits, 11·DIV clocks; even parity.
  - Undefined: PARITY state and parity logic are not compiled; DATA goes straight to STOP; frame is 10 bits, 10·DIV clocks.
- Both builds must match the receiver's parity setting.

## Test plan
Bench overrides REFERENCE_CLOCK=8, BAUD=1, giving DIV=8.
- Reset: hold reset=0 for 3 clocks -> TX_Port=1, TX_Busy=0, TX_Done=0; all three remain unchanged for 20 idle clocks after release with TX_Send=0.
- Byte 0x55 with UART_TX_PARITY_EN: pulse TX_Send for 1 clock.
  - TX_Port, sampled every 8 clocks, is 0,1,0,1,0,1,0,1,0,0(parity),1.
  - TX_Busy is high for 88 clocks; TX_Done pulses at clock 88.
- Byte 0x07 with UART_TX_PARITY_EN -> data bits 1,1,1,0,0,0,0,0, then parity bit=1, then stop=1.
- Busy protection:
  - During a 0x3C frame, change DATA_TX to 0xFF and pulse TX_Send at clock 30.
  - Line still carries 0x3C; only one TX_Done pulse; no second frame.
- Back-to-back: hold TX_Send=1 with DATA_TX=0xA5.
  - Two identical frames; second start bit falls exactly 1 clock after the first TX_Done edge; stop-to-start gap is 9 high clocks.
- Reset mid-frame, without macro:
  - Assert reset at clock 35 of a 0x00 frame -> TX_Port=1 immediately, TX_Busy=0, no TX_Done.
  - After release with TX_Send=1, a fresh 80-clock frame completes.
